ifft_r2sdf_stage: RTL and testbench

// - One streaming radix-2 single-path delay-feedback (R2SDF) DIF stage of the inverse FFT, after spectrum masking in the Hilbert datapath.
// - Recombines the spectrum back toward the time domain: butterfly a+b / a-b, conjugate-twiddle multiply on the difference path, and scaling by 1/2 per stage.
// - Stages cascade with DEPTH = N/2, N/4 ... 1. Output feeds the next stage or the analytic-signal sink.

---
 rtl/ifft_r2sdf_stage_pkg.sv | 48 ++++
 rtl/ifft_r2sdf_stage_if.sv | 33 +++
 rtl/ifft_r2sdf_stage_cmul_round_sat.sv | 25 ++
 rtl/ifft_r2sdf_stage.sv | 156 +++++++++++++++
 tb/tb_ifft_r2sdf_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ifft_r2sdf_stage_pkg.sv
// Shared types, constants and round/saturate helpers for the FFT/IFFT datapath.
//   DW      : signed width of every real/imag sample
//   TW_W    : signed twiddle width, Q1.(TW_W-1)
//   cplx_t  : packed complex sample {re, im}
//   sat_dw  : saturate a wide accumulator to DW bits
//   half_round : (x + 1) >>> 1 with saturation to DW bits
package ifft_r2sdf_stage_pkg;

    localparam int unsigned DW    = 21;
    localparam int unsigned TW_W  = 16;
    localparam int unsigned BW    = DW + 2;          // butterfly add/sub width
    localparam int unsigned ACC_W = DW + TW_W + 2;   // complex-multiply accumulator width

    localparam logic signed [TW_W-1:0] TW_ONE = {1'b0, {(TW_W-1){1'b1}}};
    localparam logic signed [DW-1:0]   DW_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]   DW_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1) <<< (TW_W - 2);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    // Twiddle-address width; a DEPTH of 1 still gets a 1-bit address port.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] x);
        logic signed [DW-1:0] r;
        if (x > ACC_W'(DW_MAX)) begin
            r = DW_MAX;
        end else if (x < ACC_W'(DW_MIN)) begin
            r = DW_MIN;
        end else begin
            r = DW'(x);
        end
        return r;
    endfunction

    // Halving with round-half-up; only a-b at the extreme corner can exceed DW bits.
    function automatic logic signed [DW-1:0] half_round(input logic signed [BW-1:0] x);
        logic signed [BW-1:0] h;
        h = (x + BW'(1)) >>> 1;
        return sat_dw(ACC_W'(h));
    endfunction

endpackage

// File: rtl/ifft_r2sdf_stage_if.sv
// Streaming sample / twiddle-ROM bundle of one R2SDF IFFT stage.
//   in_valid/in_re/in_im    : upstream sample stream
//   tw_addr/tw_re/tw_im     : twiddle ROM lookup (address out, data back same cycle)
//   out_valid/out_re/out_im : downstream sample stream
// master = environment side (upstream source, ROM, sink); slave = the stage.
interface ifft_r2sdf_stage_if #(
    parameter int unsigned DEPTH = 4
);
    import ifft_r2sdf_stage_pkg::*;

    localparam int unsigned AW = addr_w(DEPTH);

    logic                   in_valid;
    logic signed [DW-1:0]   in_re;
    logic signed [DW-1:0]   in_im;
    logic [AW-1:0]          tw_addr;
    logic signed [TW_W-1:0] tw_re;
    logic signed [TW_W-1:0] tw_im;
    logic                   out_valid;
    logic signed [DW-1:0]   out_re;
    logic signed [DW-1:0]   out_im;

    modport master (
        output in_valid, in_re, in_im, tw_re, tw_im,
        input  tw_addr, out_valid, out_re, out_im
    );

    modport slave (
        input  in_valid, in_re, in_im, tw_re, tw_im,
        output tw_addr, out_valid, out_re, out_im
    );

endinterface

// File: rtl/ifft_r2sdf_stage_cmul_round_sat.sv
// Conjugate complex multiply y = d * conj(w), rounded and saturated to DW bits.
//   d_i     : complex difference sample
//   w_re_i  : forward twiddle real part, Q1.(TW_W-1)
//   w_im_i  : forward twiddle imag part (conjugated here)
//   y_c_o   : combinational result
module cmul_round_sat
    import ifft_r2sdf_stage_pkg::*;
(
    input  cplx_t                  d_i,
    input  logic signed [TW_W-1:0] w_re_i,
    input  logic signed [TW_W-1:0] w_im_i,
    output cplx_t                  y_c_o
);

    logic signed [ACC_W-1:0] acc_re;
    logic signed [ACC_W-1:0] acc_im;

    // re = dr*wr + di*wi ; im = di*wr - dr*wi, both carrying the half-LSB round term
    assign acc_re = ACC_W'(d_i.re) * ACC_W'(w_re_i) + ACC_W'(d_i.im) * ACC_W'(w_im_i) + RND;
    assign acc_im = ACC_W'(d_i.im) * ACC_W'(w_re_i) - ACC_W'(d_i.re) * ACC_W'(w_im_i) + RND;

    assign y_c_o.re = sat_dw(acc_re >>> (TW_W - 1));
    assign y_c_o.im = sat_dw(acc_im >>> (TW_W - 1));

endmodule

// File: rtl/ifft_r2sdf_stage.sv
// One streaming radix-2 single-path delay-feedback DIF stage of the inverse FFT.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of ifft_r2sdf_stage_if (sample in, twiddle ROM, sample out)
// Fill phase stores the input and emits the previous frame's difference on the
// twiddle path; butterfly phase emits the halved sum and stores the halved
// difference. Two registered stages: select/twiddle capture, then multiply.
module ifft_r2sdf_stage
    import ifft_r2sdf_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    ifft_r2sdf_stage_if.slave bus
);

    localparam int unsigned AW = addr_w(DEPTH);
    localparam int unsigned CW = $clog2(2 * DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          primed_q, primed_d;
    logic          phase;
    logic          accept;

    cplx_t in_s, pop, push;
    cplx_t sum_c, diff_c;

    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_diff_q, s1_diff_d;
    cplx_t                  s1_data_q, s1_data_d;
    logic signed [TW_W-1:0] s1_w_re_q, s1_w_re_d;
    logic signed [TW_W-1:0] s1_w_im_q, s1_w_im_d;

    logic  out_valid_q, out_valid_d;
    cplx_t out_q, out_d;
    cplx_t cm_y;

    assign accept  = bus.in_valid;
    assign phase   = cnt_q[CW-1];
    assign in_s.re = bus.in_re;
    assign in_s.im = bus.in_im;

    // Twiddle index is the in-phase position; with DEPTH=1 only k=0 exists.
    generate
        if (DEPTH == 1) begin : g_tw_one
            assign bus.tw_addr = '0;
        end else begin : g_tw_idx
            assign bus.tw_addr = cnt_q[AW-1:0];
        end
    endgenerate

    // Delay line of DEPTH samples advancing once per accepted input.
    generate
        if (DEPTH <= 8) begin : g_sr
            cplx_t dl_q [DEPTH];
            always_ff @(posedge clk) begin
                if (accept) begin
                    dl_q[0] <= push;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        dl_q[i] <= dl_q[i-1];
                    end
                end
            end
            assign pop = dl_q[DEPTH-1];
        end else begin : g_ram
            // Read-before-write at the same slot gives exactly DEPTH accepts of delay.
            cplx_t ram_q [DEPTH];
            always_ff @(posedge clk) begin
                if (accept) begin
                    ram_q[cnt_q[AW-1:0]] <= push;
                end
            end
            assign pop = ram_q[cnt_q[AW-1:0]];
        end
    endgenerate

    // Butterfly on delay pop (a) and input (b), halved per stage.
    assign sum_c.re  = half_round(BW'(pop.re) + BW'(in_s.re));
    assign sum_c.im  = half_round(BW'(pop.im) + BW'(in_s.im));
    assign diff_c.re = half_round(BW'(pop.re) - BW'(in_s.re));
    assign diff_c.im = half_round(BW'(pop.im) - BW'(in_s.im));

    cmul_round_sat u_cmul (
        .d_i    (s1_data_q),
        .w_re_i (s1_w_re_q),
        .w_im_i (s1_w_im_q),
        .y_c_o  (cm_y)
    );

    // Next-state: counter/priming, stage-1 select, stage-2 twiddle or bypass.
    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        push        = in_s;
        s1_valid_d  = 1'b0;
        s1_diff_d   = s1_diff_q;
        s1_data_d   = s1_data_q;
        s1_w_re_d   = s1_w_re_q;
        s1_w_im_d   = s1_w_im_q;
        out_valid_d = s1_valid_q;
        out_d       = out_q;

        if (accept) begin
            cnt_d     = cnt_q + CW'(1);
            s1_w_re_d = bus.tw_re;
            s1_w_im_d = bus.tw_im;
            if (phase) begin
                primed_d   = 1'b1;
                push       = diff_c;
                s1_valid_d = 1'b1;
                s1_diff_d  = 1'b0;
                s1_data_d  = sum_c;
            end else begin
                // Pops before the first butterfly after reset hold stale data.
                push       = in_s;
                s1_valid_d = primed_q;
                s1_diff_d  = 1'b1;
                s1_data_d  = pop;
            end
        end

        if (s1_valid_q) begin
            out_d = s1_diff_q ? cm_y : s1_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= 1'b0;
            s1_data_q   <= '0;
            s1_w_re_q   <= '0;
            s1_w_im_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            s1_valid_q  <= s1_valid_d;
            s1_diff_q   <= s1_diff_d;
            s1_data_q   <= s1_data_d;
            s1_w_re_q   <= s1_w_re_d;
            s1_w_im_q   <= s1_w_im_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_q.re;
    assign bus.out_im    = out_q.im;

endmodule

// File: tb/tb_ifft_r2sdf_stage.sv
// Directed bench for ifft_r2sdf_stage with DEPTH=4: one frame of 8 plus a
// 4-zero flush per test, hand-computed expected outputs.
module tb_ifft_r2sdf_stage;
    import ifft_r2sdf_stage_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    int q_re[$];
    int q_im[$];
    int q_cyc[$];
    int acc_cyc[$];

    logic                   tw_ovr;
    logic signed [TW_W-1:0] ovr_re;
    logic signed [TW_W-1:0] ovr_im;

    int fr_re[12];
    int fr_im[12];
    int ex_re[8];
    int ex_im[8];

    ifft_r2sdf_stage_if #(.DEPTH(DEPTH)) bus ();

    ifft_r2sdf_stage #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Twiddle ROM: forward w_k = cos(2*pi*k/8) - j*sin(2*pi*k/8)
    always_comb begin
        if (tw_ovr) begin
            bus.tw_re = ovr_re;
            bus.tw_im = ovr_im;
        end else begin
            case (bus.tw_addr)
                2'd0:    begin bus.tw_re = TW_ONE;     bus.tw_im = 16'sd0;      end
                2'd1:    begin bus.tw_re = 16'sd23170; bus.tw_im = -16'sd23170; end
                2'd2:    begin bus.tw_re = 16'sd0;     bus.tw_im = -16'sd32767; end
                default: begin bus.tw_re = -16'sd23170; bus.tw_im = -16'sd23170; end
            endcase
        end
    end

    // Output capture, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            q_re.push_back(int'(bus.out_re));
            q_im.push_back(int'(bus.out_im));
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_capture();
        q_re.delete();
        q_im.delete();
        q_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic step(input logic v, input int re, input int im);
        bus.in_valid = v;
        bus.in_re    = DW'(re);
        bus.in_im    = DW'(im);
        if (v) acc_cyc.push_back(cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_capture();
    endtask

    // Frame of 8 plus 4-zero flush; optional idle cycle between accepts.
    task automatic run_frame(input string tag, input bit gaps);
        for (int i = 0; i < 12; i++) begin
            if (gaps && (i % 2 == 1)) step(1'b0, 0, 0);
            step(1'b1, fr_re[i], fr_im[i]);
            if (i == 3) begin
                step(1'b0, 0, 0);
                step(1'b0, 0, 0);
                chk({tag, " priming"}, q_re.size(), 0);
            end
            if (i == 6) chk({tag, " tw_addr k7"}, int'(bus.tw_addr), 3);
            if (i == 7) chk({tag, " tw_addr wrap"}, int'(bus.tw_addr), 0);
        end
        repeat (4) step(1'b0, 0, 0);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, " count"}, q_re.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < q_re.size()) begin
                chk($sformatf("%s re[%0d]", tag, i), q_re[i], ex_re[i]);
                chk($sformatf("%s im[%0d]", tag, i), q_im[i], ex_im[i]);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        tw_ovr       = 1'b0;
        ovr_re       = '0;
        ovr_im       = '0;
        bus.in_valid = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset out_re", int'(bus.out_re), 0);
        chk("reset out_im", int'(bus.out_im), 0);
        chk("reset tw_addr", int'(bus.tw_addr), 0);

        // Impulse at index 0
        do_reset();
        fr_re = '{1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        fr_im = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_frame("impulse0", 1'b0);
        ex_re = '{500, 0, 0, 0, 500, 0, 0, 0};
        ex_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_frame("impulse0");

        // Impulse at index 1, difference rotated by conj(w1)
        do_reset();
        fr_re = '{0, 1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_frame("impulse1", 1'b0);
        ex_re = '{0, 500, 0, 0, 0, 354, 0, 0};
        ex_im = '{0, 0, 0, 0, 0, 354, 0, 0};
        check_frame("impulse1");

        // Saturating twiddle product
        do_reset();
        tw_ovr = 1'b1;
        ovr_re = 16'sd23170;
        ovr_im = 16'sd23170;
        fr_re = '{1048575, 0, 0, 0, -1048575, 0, 0, 0, 0, 0, 0, 0};
        fr_im = '{1048575, 0, 0, 0, -1048575, 0, 0, 0, 0, 0, 0, 0};
        run_frame("sat", 1'b0);
        ex_re = '{0, 0, 0, 0, 1048575, 0, 0, 0};
        ex_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_frame("sat");
        tw_ovr = 1'b0;

        // Negative rounding, -j twiddle, 50% in_valid duty, latency
        do_reset();
        fr_re = '{-1001, 0, 301, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        fr_im = '{0, 0, -700, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_frame("gaps", 1'b1);
        ex_re = '{-500, 0, 151, 0, -500, 0, 350, 0};
        ex_im = '{0, 0, -350, 0, 0, 0, 151, 0};
        check_frame("gaps");
        for (int i = 0; i < 8; i++) begin
            if (i < q_cyc.size() && (i + 4) < acc_cyc.size()) begin
                chk($sformatf("gaps latency[%0d]", i), q_cyc[i] - acc_cyc[i + 4], 2);
            end
        end

        // Reset mid-frame, then a DC frame
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 777, -5);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst out_valid", int'(bus.out_valid), 0);
        rst = 1'b0;
        clear_capture();
        fr_re = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 0, 0, 0, 0};
        fr_im = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_frame("dc", 1'b0);
        ex_re = '{1000, 1000, 1000, 1000, 0, 0, 0, 0};
        ex_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_frame("dc");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
